// File: rtl/counter4_divider_if.sv
// Output bundle of counter4_divider: one bit per divide-by-2 stage.
// With COUNTER4_TERMINAL_EN defined the bundle also carries the terminal-count flag tc.
interface counter4_divider_if;
   logic out0;
   logic out1;
   logic out2;
   logic out3;
`ifdef COUNTER4_TERMINAL_EN
   logic tc;

   modport master (output out0, output out1, output out2, output out3, output tc);
   modport slave  (input  out0, input  out1, input  out2, input  out3, input  tc);
`else
   modport master (output out0, output out1, output out2, output out3);
   modport slave  (input  out0, input  out1, input  out2, input  out3);
`endif
endinterface

// File: rtl/counter4_divider.sv
// Free-running synchronous 4-bit up-counter; each bit is a divide-by-2 stage (clk/2 .. clk/16).
// Optional macro COUNTER4_TERMINAL_EN adds a registered terminal-count flag tc.
module counter4_divider #(
   parameter int MODULUS     = 16,
   parameter int RESET_VALUE = 0
) (
   input  logic               clk,
   input  logic               rst,
   counter4_divider_if.master bus
);

   localparam logic [3:0] LAST_CNT  = 4'(MODULUS - 1);
   localparam logic [3:0] RESET_CNT = 4'(RESET_VALUE);

   logic [3:0] cnt_reg;
   logic [3:0] cnt_next;

   // All bits update from one register on the same edge, so the wrap is glitch-free.
   always_comb begin
      cnt_next = cnt_reg + 4'd1;
      if (cnt_reg == LAST_CNT) begin
         cnt_next = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= RESET_CNT;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign bus.out0 = cnt_reg[0];
   assign bus.out1 = cnt_reg[1];
   assign bus.out2 = cnt_reg[2];
   assign bus.out3 = cnt_reg[3];

`ifdef COUNTER4_TERMINAL_EN
   logic tc_reg;

   // Registered look-ahead: tc is high exactly while cnt_reg holds the last count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tc_reg <= 1'b0;
      end else begin
         tc_reg <= (cnt_next == LAST_CNT);
      end
   end

   assign bus.tc = tc_reg;
`endif

endmodule

// File: tb/tb_counter4_divider.sv
// Randomized self-checking bench for counter4_divider (MODULUS 16 and 10) against a modulo-arithmetic model.
module tb_counter4_divider;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   counter4_divider_if bus16 ();
   counter4_divider_if bus10 ();

   counter4_divider #(.MODULUS(16), .RESET_VALUE(0)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   counter4_divider #(.MODULUS(10), .RESET_VALUE(3)) dut10 (
      .clk (clk),
      .rst (rst),
      .bus (bus10)
   );

   logic [3:0] v16;
   logic [3:0] v10;
   assign v16 = {bus16.out3, bus16.out2, bus16.out1, bus16.out0};
   assign v10 = {bus10.out3, bus10.out2, bus10.out1, bus10.out0};

   int n_tests = 0;
   int n_fail  = 0;
   int m16     = 0;
   int m10     = 3;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/m16"}, 8'(v16), 8'(m16));
      check({tag, "/m10"}, 8'(v10), 8'(m10));
`ifdef COUNTER4_TERMINAL_EN
      check({tag, "/tc16"}, 8'(bus16.tc), 8'(m16 == 15));
      check({tag, "/tc10"}, 8'(bus10.tc), 8'(m10 == 9));
`endif
   endtask

   task automatic model_reset();
      m16 = 0;
      m10 = 3;
   endtask

   // One counted edge: advance the model, sample on the falling edge.
   task automatic step(input string tag);
      @(posedge clk);
      m16 = (m16 + 1) % 16;
      m10 = (m10 + 1) % 10;
      @(negedge clk);
      $display("[TB] %s: cnt16=%0d (exp %0d) cnt10=%0d (exp %0d)", tag, v16, m16, v10, m10);
      check_all(tag);
   endtask

   // Assert reset at a negedge, hold for 'edges' rising edges, release at a later negedge.
   task automatic reset_hold(input string tag, input int edges);
      @(negedge clk);
      #1 rst = 1'b0;
      model_reset();
      #1 check_all({tag, "_async"});
      for (int i = 0; i < edges; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_all({tag, "_hold"});
      end
      rst = 1'b1;
      $display("[TB] %s: reset held %0d edges, released", tag, edges);
   endtask

   initial begin
      int rises [4];
      int highs [4];
      logic [3:0] prev;

      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_all("reset");
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_all("reset_hold");
      end
      rst = 1'b1;

      for (int i = 0; i < 16; i++) step("seq");
      check(8'(v16) == 8'd0 ? "seq_wrap" : "seq_wrap", 8'(v16), 8'd0);

      // Divider ratios and duty cycle over 32 edges starting from 0000.
      for (int b = 0; b < 4; b++) begin
         rises[b] = 0;
         highs[b] = 0;
      end
      prev = v16;
      for (int i = 0; i < 32; i++) begin
         step("ratio");
         for (int b = 0; b < 4; b++) begin
            if (v16[b] && !prev[b]) rises[b]++;
            if (v16[b]) highs[b]++;
         end
         prev = v16;
      end
      for (int b = 0; b < 4; b++) begin
         check($sformatf("rises_out%0d", b), 8'(rises[b]), 8'(32 >> (b + 1)));
         check($sformatf("duty_out%0d", b), 8'(highs[b]), 8'd16);
      end

      // Async reset at count 5, then restart.
      reset_hold("pre5", 1);
      for (int i = 0; i < 5; i++) step("to5");
      #1 rst = 1'b0;
      model_reset();
      #1 check_all("mid5_async");
      @(negedge clk);
      rst = 1'b1;
      step("after_mid5");

      // Reset re-asserted right after a full wrap, 3 edges held.
      reset_hold("pre_wrap", 1);
      for (int i = 0; i < 16; i++) step("wrap16");
      reset_hold("post_wrap", 3);
      step("post_wrap_release");

      // Random run with occasional asynchronous resets.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            reset_hold("rnd_rst", int'($urandom_range(1, 3)));
         end else begin
            step("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
